alu_request_arbiter: RTL and testbench
======================================

ALU_REQUEST_ARBITER -- requirements
Module: alu_request_arbiter

Interface
REQ-001 Parameter: ALU_LATENCY, default 1, cycles from ALU operand sample to alu_active/result valid; legal range 1..7.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; request handshake when req_valid[i] & req_ready[i].
REQ-006 req_opcode_0 / req_opcode_1  input  7 each  opcode from requester i.
REQ-007 req_funct3_0 / req_funct3_1  input  3 each  subfunction_3 from requester i.
REQ-008 req_rs1_0 / req_rs1_1  input  32 each  source register value from requester i.
REQ-009 req_imm_0 / req_imm_1  input  32 each  sign-extended I-type immediate from requester i.
REQ-010 rsp_valid  output  2  one-hot response valid to requester i.
REQ-011 rsp_ready  input  2  requester i accepts response.
REQ-012 rsp_result  output  32  shared response data, meaningful when any rsp_valid bit is set.
REQ-013 rsp_error  output  1  response carries decode error or timeout.
REQ-014 alu_opcode  output  7; alu_subfunction_3  output  3; alu_rs1  output  32; alu_imm  output  32; operands to the shared I-type ALU.
REQ-015 alu_active  input  1; alu_decoding_error  input  1; alu_result  input  32; registered ALU status/result.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESPOND; reset state IDLE.
REQ-017 IDLE: req_ready = grant one-hot combinationally; no valid -> req_ready = 0, stay IDLE.
REQ-018 Arbitration: one valid -> grant it; both valid -> grant requester != last_grant (round-robin); last_grant resets to 1 so requester 0 wins first contention.
REQ-019 On handshake: latch opcode, funct3, rs1, imm and grant index into operand registers, update last_grant, go ISSUE.
REQ-020 ISSUE: drive latched operands onto alu_* for exactly one cycle; then WAIT, load wait counter with ALU_LATENCY.
REQ-021 Outside ISSUE: alu_opcode = 7'h00 (ALU disabled); alu_subfunction_3, alu_rs1, alu_imm hold latched values.
REQ-022 WAIT: decrement counter each cycle; when counter reaches 1 sample alu_active, alu_decoding_error, alu_result and go RESPOND.
REQ-023 Sample with alu_active=1: rsp_result = alu_result, rsp_error = alu_decoding_error.
REQ-024 Sample with alu_active=0 (opcode not accepted by ALU): rsp_result = 0, rsp_error = 1 (timeout).
REQ-025 RESPOND: rsp_valid[grant] = 1, rsp_result/rsp_error stable until rsp_ready[grant]; on that edge go IDLE. rsp_ready of other bit ignored.
REQ-026 End-to-end: handshake at edge N -> rsp_valid high from edge N+1+ALU_LATENCY+1 (N+3 for default); throughput <= 1 op per 4 cycles.
REQ-027 At most one request outstanding; req_ready = 0 in ISSUE, WAIT, RESPOND.
REQ-028 req_valid dropping while not granted: no effect; requester need not hold it.
REQ-029 Requester holding req_valid while in RESPOND: not accepted before returning to IDLE.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, last_grant 1, counter 0, operand registers 0, rsp_valid 0, rsp_result 0, rsp_error 0, alu_opcode 0, req_ready 0 while rst_n low.
REQ-031 Reset mid-operation (ISSUE/WAIT/RESPOND) abandons the transaction; no response issued after rst_n rises.
REQ-032 First request accepted in the first IDLE cycle after rst_n deasserts.

Verification
REQ-033 Single op: req0 ADDI rs1=5, imm=0xFFFFFFFF -> rsp_valid=01 at edge N+3, rsp_result=4, rsp_error=0.
REQ-034 Contention: both valid continuously, rsp_ready=11 -> grants alternate 0,1,0,1; req1 SLTIU rs1=3 imm=7 -> result 1.
REQ-035 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_result stable, req_ready=00 throughout, accept next req only after release.
REQ-036 Timeout: req0 opcode 0x33 -> rsp_error=1, rsp_result=0, FSM back to IDLE.
REQ-037 Async reset asserted in WAIT -> outputs zero immediately, no rsp_valid after deassert; following request completes normally.
REQ-038 ALU_LATENCY=3 with delay-modelled ALU -> rsp_valid at N+5, correct XORI result.

Source files
------------

// File: rtl/alu_request_arbiter.sv
// alu_request_arbiter
//   Shares one I-type ALU between two requesters. A round-robin arbiter
//   accepts one request at a time. The accepted operands are driven to the
//   ALU for a single ISSUE cycle, and the ALU status and result are sampled
//   ALU_LATENCY cycles later. The response is then held until the owning
//   requester accepts it.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and
//   ready are both high. Ready never depends on the same requester's data.
//   Valid/data stay stable until the transfer edge.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]  per-requester request handshake
//   req_opcode_i, req_funct3_i, req_rs1_i, req_imm_i   request operands
//   rsp_valid [1:0]            one-hot response valid (bit = owner)
//   rsp_ready [1:0]            per-requester response accept
//   rsp_result, rsp_error      shared response payload
//   alu_opcode, alu_subfunction_3, alu_rs1, alu_imm    ALU operands
//   alu_active, alu_decoding_error, alu_result         registered ALU outputs
//   dbg_state                  current FSM state (IDLE=0 ISSUE=1 WAIT=2 RESPOND=3)
module alu_request_arbiter #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [6:0]  req_opcode_0,
  input  logic [6:0]  req_opcode_1,
  input  logic [2:0]  req_funct3_0,
  input  logic [2:0]  req_funct3_1,
  input  logic [31:0] req_rs1_0,
  input  logic [31:0] req_rs1_1,
  input  logic [31:0] req_imm_0,
  input  logic [31:0] req_imm_1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_error,
  output logic [6:0]  alu_opcode,
  output logic [2:0]  alu_subfunction_3,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_imm,
  input  logic        alu_active,
  input  logic        alu_decoding_error,
  input  logic [31:0] alu_result,
  output logic [1:0]  dbg_state
);

  // Out-of-range latencies are clamped so the 3-bit counter never wraps.
  localparam int unsigned LAT_C = (ALU_LATENCY < 1) ? 1 :
                                  ((ALU_LATENCY > 7) ? 7 : ALU_LATENCY);
  localparam logic [2:0]  LAT   = 3'(LAT_C);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        last_grant;
  logic        grant_idx;
  logic        handshake;
  logic [2:0]  wait_cnt;
  logic        op_idx;
  logic [6:0]  op_opcode;
  logic [2:0]  op_funct3;
  logic [31:0] op_rs1;
  logic [31:0] op_imm;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state and FSM-driven outputs
  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    alu_opcode = 7'h00;
    handshake  = 1'b0;
    // On contention, the requester that did not win last time is granted.
    // With a single valid request, bit 1 alone selects requester 1.
    grant_idx  = (&req_valid) ? ~last_grant : req_valid[1];
    case (state)
      S_IDLE: begin
        // rst_n gating keeps ready low for the whole reset assertion.
        if (rst_n && (|req_valid)) begin
          req_ready  = grant_idx ? 2'b10 : 2'b01;
          handshake  = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        alu_opcode = op_opcode;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == 3'd1) state_next = S_RESPOND;
      end
      S_RESPOND: begin
        rsp_valid = op_idx ? 2'b10 : 2'b01;
        if (rsp_ready[op_idx]) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture, wait counter and response sampling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      wait_cnt   <= 3'd0;
      op_idx     <= 1'b0;
      op_opcode  <= 7'h00;
      op_funct3  <= 3'h0;
      op_rs1     <= 32'h0;
      op_imm     <= 32'h0;
      rsp_result <= 32'h0;
      rsp_error  <= 1'b0;
    end else begin
      if (handshake) begin
        op_idx     <= grant_idx;
        last_grant <= grant_idx;
        op_opcode  <= grant_idx ? req_opcode_1 : req_opcode_0;
        op_funct3  <= grant_idx ? req_funct3_1 : req_funct3_0;
        op_rs1     <= grant_idx ? req_rs1_1    : req_rs1_0;
        op_imm     <= grant_idx ? req_imm_1    : req_imm_0;
      end
      if (state == S_ISSUE) wait_cnt <= LAT;
      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 3'd1;
        if (wait_cnt == 3'd1) begin
          // An inactive ALU means it refused the opcode: report a timeout.
          rsp_result <= alu_active ? alu_result : 32'h0;
          rsp_error  <= alu_active ? alu_decoding_error : 1'b1;
        end
      end
    end
  end

  // Non-opcode operands simply hold the captured values; the ALU ignores
  // them while alu_opcode is zero.
  assign alu_subfunction_3 = op_funct3;
  assign alu_rs1           = op_rs1;
  assign alu_imm           = op_imm;
  assign dbg_state         = state;

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Bench for alu_request_arbiter: one instance with the default latency and
// one with ALU_LATENCY=3, each attached to a registered I-type ALU model.
// Expected responses are queued when a request is driven and compared when
// the response handshake occurs.
module tb_alu_request_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A (latency 1) ----------------
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [6:0]  req_opcode_0, req_opcode_1, alu_opcode;
  logic [2:0]  req_funct3_0, req_funct3_1, alu_subfunction_3;
  logic [31:0] req_rs1_0, req_rs1_1, req_imm_0, req_imm_1;
  logic [31:0] rsp_result, alu_rs1, alu_imm, alu_result;
  logic        rsp_error, alu_active, alu_decoding_error;
  logic [1:0]  dbg_state;

  alu_request_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode_0(req_opcode_0), .req_opcode_1(req_opcode_1),
    .req_funct3_0(req_funct3_0), .req_funct3_1(req_funct3_1),
    .req_rs1_0(req_rs1_0), .req_rs1_1(req_rs1_1),
    .req_imm_0(req_imm_0), .req_imm_1(req_imm_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_error(rsp_error),
    .alu_opcode(alu_opcode), .alu_subfunction_3(alu_subfunction_3),
    .alu_rs1(alu_rs1), .alu_imm(alu_imm),
    .alu_active(alu_active), .alu_decoding_error(alu_decoding_error),
    .alu_result(alu_result), .dbg_state(dbg_state)
  );

  // ---------------- DUT B (latency 3) ----------------
  logic [1:0]  b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [6:0]  b_req_opcode_0, b_req_opcode_1, b_alu_opcode;
  logic [2:0]  b_req_funct3_0, b_req_funct3_1, b_alu_subfunction_3;
  logic [31:0] b_req_rs1_0, b_req_rs1_1, b_req_imm_0, b_req_imm_1;
  logic [31:0] b_rsp_result, b_alu_rs1, b_alu_imm, b_alu_result;
  logic        b_rsp_error, b_alu_active, b_alu_decoding_error;
  logic [1:0]  b_dbg_state;

  alu_request_arbiter #(.ALU_LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_opcode_0(b_req_opcode_0), .req_opcode_1(b_req_opcode_1),
    .req_funct3_0(b_req_funct3_0), .req_funct3_1(b_req_funct3_1),
    .req_rs1_0(b_req_rs1_0), .req_rs1_1(b_req_rs1_1),
    .req_imm_0(b_req_imm_0), .req_imm_1(b_req_imm_1),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_result(b_rsp_result), .rsp_error(b_rsp_error),
    .alu_opcode(b_alu_opcode), .alu_subfunction_3(b_alu_subfunction_3),
    .alu_rs1(b_alu_rs1), .alu_imm(b_alu_imm),
    .alu_active(b_alu_active), .alu_decoding_error(b_alu_decoding_error),
    .alu_result(b_alu_result), .dbg_state(b_dbg_state)
  );

  // ---------------- ALU model: {active, error, result} ----------------
  function automatic logic [33:0] alu_eval(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [31:0] rs1, input logic [31:0] imm);
    logic        act;
    logic        err;
    logic [31:0] res;
    act = (op == 7'h13);
    err = 1'b0;
    res = 32'h0;
    if (act) begin
      case (f3)
        3'd0: res = rs1 + imm;
        3'd1: begin res = rs1 << imm[4:0]; err = (imm[11:5] != 7'h00); end
        3'd2: res = {31'b0, $signed(rs1) < $signed(imm)};
        3'd3: res = {31'b0, rs1 < imm};
        3'd4: res = rs1 ^ imm;
        3'd5: begin
          res = imm[10] ? 32'($signed(rs1) >>> imm[4:0]) : (rs1 >> imm[4:0]);
          err = (imm[11:5] != 7'h00) && (imm[11:5] != 7'h20);
        end
        3'd6: res = rs1 | imm;
        default: res = rs1 & imm;
      endcase
    end
    return {act, err, res};
  endfunction

  logic [33:0] pipe_a = '0;
  logic [33:0] pipe_b [3] = '{default: '0};
  always @(posedge clk) begin
    pipe_a    <= alu_eval(alu_opcode, alu_subfunction_3, alu_rs1, alu_imm);
    pipe_b[0] <= alu_eval(b_alu_opcode, b_alu_subfunction_3, b_alu_rs1, b_alu_imm);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign alu_active           = pipe_a[33];
  assign alu_decoding_error   = pipe_a[32];
  assign alu_result           = pipe_a[31:0];
  assign b_alu_active         = pipe_b[2][33];
  assign b_alu_decoding_error = pipe_b[2][32];
  assign b_alu_result         = pipe_b[2][31:0];

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: {one-hot owner, error, result}
  logic [34:0] exp_q[$];
  logic [34:0] exp_b_q[$];
  logic [34:0] e_a, e_b;
  int rsp_count = 0;
  int rsp_count_b = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (rsp_valid & rsp_ready) != 2'b00) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'h0);
      else begin
        e_a = exp_q.pop_front();
        chk("rsp", 64'({rsp_valid, rsp_error, rsp_result}), 64'(e_a));
      end
      rsp_count++;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (b_rsp_valid & b_rsp_ready) != 2'b00) begin
      if (exp_b_q.size() == 0) chk("rsp_b_unexpected", 64'(b_rsp_valid), 64'h0);
      else begin
        e_b = exp_b_q.pop_front();
        chk("rsp_b", 64'({b_rsp_valid, b_rsp_error, b_rsp_result}), 64'(e_b));
      end
      rsp_count_b++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [31:0] imm);
    if (idx == 0) begin
      req_opcode_0 = op; req_funct3_0 = f3; req_rs1_0 = rs1; req_imm_0 = imm;
    end else begin
      req_opcode_1 = op; req_funct3_1 = f3; req_rs1_1 = rs1; req_imm_1 = imm;
    end
  endtask

  // Returns #1 after the request handshake edge, with the DUT in ISSUE.
  task automatic issue(input int idx, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] rs1, input logic [31:0] imm);
    int n;
    set_req(idx, op, f3, rs1, imm);
    req_valid[idx] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[idx] && n < 30) begin
      tick();
      n++;
    end
    chk("issue_ready", 64'(req_ready[idx]), 64'h1);
    tick();
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 60 && rsp_count < target; i++) tick();
    chk("rsp_wait", 64'(rsp_count), 64'(target));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    req_valid = 2'b11; rsp_ready = 2'b00;
    set_req(0, 7'h0, 3'h0, 32'h0, 32'h0);
    set_req(1, 7'h0, 3'h0, 32'h0, 32'h0);
    b_req_valid = 2'b00; b_rsp_ready = 2'b00;
    b_req_opcode_0 = 7'h0; b_req_opcode_1 = 7'h0;
    b_req_funct3_0 = 3'h0; b_req_funct3_1 = 3'h0;
    b_req_rs1_0 = 32'h0; b_req_rs1_1 = 32'h0;
    b_req_imm_0 = 32'h0; b_req_imm_1 = 32'h0;
    tick(); tick();

    // Reset state
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_alu_opcode", 64'(alu_opcode), 64'h0);
    chk("rst_rsp_result", 64'(rsp_result), 64'h0);
    chk("rst_rsp_error", 64'(rsp_error), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'h0);

    // Contention: both held, grants alternate 0,1,0,1
    set_req(0, 7'h13, 3'd0, 32'd5, 32'hFFFF_FFFF);
    set_req(1, 7'h13, 3'd3, 32'd3, 32'd7);
    exp_q.push_back({2'b01, 1'b0, 32'd4});
    exp_q.push_back({2'b10, 1'b0, 32'd1});
    exp_q.push_back({2'b01, 1'b0, 32'd4});
    exp_q.push_back({2'b10, 1'b0, 32'd1});
    rsp_ready = 2'b11;
    rst_n = 1'b1;
    #1;
    chk("first_grant", 64'(req_ready), 64'h1);
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 2'b00) n++;
    end
    chk("contention_accepts", 64'(n), 64'd4);
    tick();
    req_valid = 2'b00;
    wait_rsp(4);

    // Single op with exact timing
    set_req(0, 7'h13, 3'd0, 32'd5, 32'hFFFF_FFFF);
    exp_q.push_back({2'b01, 1'b0, 32'd4});
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    #1;
    chk("idle_ready", 64'(req_ready), 64'h1);
    tick();                                   // edge N
    req_valid = 2'b00;
    chk("issue_state", 64'(dbg_state), 64'd1);
    chk("issue_opcode", 64'(alu_opcode), 64'h13);
    chk("issue_f3", 64'(alu_subfunction_3), 64'h0);
    chk("issue_rs1", 64'(alu_rs1), 64'd5);
    chk("issue_imm", 64'(alu_imm), 64'hFFFF_FFFF);
    tick();                                   // edge N+1
    chk("wait_state", 64'(dbg_state), 64'd2);
    chk("wait_opcode_off", 64'(alu_opcode), 64'h0);
    chk("wait_imm_hold", 64'(alu_imm), 64'hFFFF_FFFF);
    chk("wait_no_rsp", 64'(rsp_valid), 64'h0);
    tick();                                   // edge N+2: visible at edge N+3
    chk("rsp_valid_n3", 64'(rsp_valid), 64'h1);
    rsp_ready = 2'b01;
    tick();
    chk("rsp_cleared", 64'(rsp_valid), 64'h0);
    chk("back_idle", 64'(dbg_state), 64'd0);

    // Backpressure on requester 1; requester 0 waits; rsp_ready[0] ignored
    rsp_ready = 2'b01;
    exp_q.push_back({2'b10, 1'b0, 32'h0000_00AF});
    exp_q.push_back({2'b01, 1'b0, 32'd13});
    issue(1, 7'h13, 3'd6, 32'h0000_00A0, 32'h0000_000F);
    set_req(0, 7'h13, 3'd0, 32'd10, 32'd3);
    req_valid = 2'b01;
    for (int i = 0; i < 20 && rsp_valid != 2'b10; i++) tick();
    chk("bp_rsp_valid", 64'(rsp_valid), 64'h2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 64'(rsp_valid), 64'h2);
      chk("bp_hold_result", 64'(rsp_result), 64'h0000_00AF);
      chk("bp_req_ready", 64'(req_ready), 64'h0);
    end
    rsp_ready = 2'b10;
    tick();
    chk("bp_idle", 64'(dbg_state), 64'd0);
    chk("bp_next_ready", 64'(req_ready), 64'h1);
    rsp_ready = 2'b11;
    tick();
    req_valid = 2'b00;
    wait_rsp(7);

    // Timeout: R-type opcode is not accepted by the ALU
    exp_q.push_back({2'b01, 1'b1, 32'h0});
    issue(0, 7'h33, 3'd0, 32'd1, 32'd1);
    wait_rsp(8);
    chk("timeout_idle", 64'(dbg_state), 64'd0);

    // Decode error reported by an active ALU keeps its result
    exp_q.push_back({2'b10, 1'b1, 32'd2});
    issue(1, 7'h13, 3'd1, 32'd1, 32'h0000_0401);
    wait_rsp(9);

    // Asynchronous reset while in WAIT abandons the transaction
    issue(0, 7'h13, 3'd0, 32'd5, 32'hFFFF_FFFF);
    tick();
    chk("rw_in_wait", 64'(dbg_state), 64'd2);
    set_req(0, 7'h13, 3'd7, 32'h0000_00FF, 32'h0000_003C);
    req_valid = 2'b01;
    exp_q.push_back({2'b01, 1'b0, 32'h0000_003C});
    #2 rst_n = 1'b0;
    #1;
    chk("rw_state", 64'(dbg_state), 64'd0);
    chk("rw_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rw_rsp_result", 64'(rsp_result), 64'h0);
    chk("rw_rsp_error", 64'(rsp_error), 64'h0);
    chk("rw_alu_opcode", 64'(alu_opcode), 64'h0);
    chk("rw_alu_rs1", 64'(alu_rs1), 64'h0);
    chk("rw_req_ready", 64'(req_ready), 64'h0);
    tick(); tick();
    chk("rw_req_ready_held", 64'(req_ready), 64'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    wait_rsp(10);

    // ALU_LATENCY=3 instance: XORI
    b_req_opcode_0 = 7'h13; b_req_funct3_0 = 3'd4;
    b_req_rs1_0 = 32'h0000_0F0F; b_req_imm_0 = 32'h0000_00FF;
    exp_b_q.push_back({2'b01, 1'b0, 32'h0000_0FF0});
    b_rsp_ready = 2'b01;
    b_req_valid = 2'b01;
    #1;
    chk("lat3_ready", 64'(b_req_ready), 64'h1);
    tick();                                   // edge N
    b_req_valid = 2'b00;
    tick(); tick(); tick();                   // edge N+3
    chk("lat3_not_yet", 64'(b_rsp_valid), 64'h0);
    tick();                                   // edge N+4: visible at edge N+5
    chk("lat3_rsp_valid", 64'(b_rsp_valid), 64'h1);
    for (int i = 0; i < 20 && rsp_count_b < 1; i++) tick();
    chk("lat3_rsp_count", 64'(rsp_count_b), 64'd1);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("queue_b_empty", 64'(exp_b_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
